// File: rtl/demux_scan.sv
// Registered 1:N demux with auto-scan sequencer and one-hot glitch-free outputs.
// Define DEMUX_SCAN_BLANK_EN to blank Y for BLANK cycles after each channel change.
module demux_scan #(
  parameter int N     = 16,
  parameter int SW    = 4,
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          E,
  input  logic          MODE,
  input  logic [SW-1:0] S,
  input  logic          HOLD,
  output logic [N-1:0]  Y,
  output logic [SW-1:0] IDX,
  output logic          WRAP
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [SW-1:0] IDX_MAX = SW'(N - 1);

  if (SW != $clog2(N) || DIV < 2 || BLANK < 1 || BLANK >= DIV)
  begin : g_bad_cfg
    $error("demux_scan: inconsistent N/SW/DIV/BLANK");
  end

  logic [CW-1:0] r_cnt;
  logic [SW-1:0] w_idx_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_wrap_nxt;
  logic [N-1:0]  w_hot;

  always_comb begin
    w_idx_nxt  = IDX;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (!MODE) begin
      w_idx_nxt = S;
      w_cnt_nxt = '0;
    end else if (HOLD) begin
      w_idx_nxt = IDX;
      w_cnt_nxt = r_cnt;
    end else if (r_cnt == CNT_MAX) begin
      w_idx_nxt  = IDX + SW'(1);
      w_cnt_nxt  = '0;
      w_wrap_nxt = (IDX == IDX_MAX);
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_hot            = '0;
    w_hot[w_idx_nxt] = E;
  end

`ifdef DEMUX_SCAN_BLANK_EN
  typedef enum logic {
    RUN  = 1'b0,
    BLNK = 1'b1
  } st_t;

  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  st_t           r_st;
  logic [BW-1:0] r_bcnt;

  // Any IDX change (re)starts the blank window, even mid-blank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_st   <= RUN;
      r_bcnt <= '0;
      r_cnt  <= '0;
      IDX    <= '0;
      WRAP   <= 1'b0;
      Y      <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      IDX   <= w_idx_nxt;
      WRAP  <= w_wrap_nxt;
      if (w_idx_nxt != IDX) begin
        r_st   <= BLNK;
        r_bcnt <= BW'(BLANK - 1);
        Y      <= '0;
      end else if (r_st == BLNK && r_bcnt != '0) begin
        r_bcnt <= r_bcnt - BW'(1);
        Y      <= '0;
      end else begin
        r_st <= RUN;
        Y    <= w_hot;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
      IDX   <= '0;
      WRAP  <= 1'b0;
      Y     <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      IDX   <= w_idx_nxt;
      WRAP  <= w_wrap_nxt;
      Y     <= w_hot;
    end
  end
`endif

endmodule

// File: tb/tb_demux_scan.sv
// Self-checking bench for demux_scan (N=16, DIV=4, BLANK=2).
// Scoreboard of expected Y/IDX/WRAP plus hand-derived scenario checks.
module tb_demux_scan;

  localparam int N     = 16;
  localparam int SW    = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 2;
`ifdef DEMUX_SCAN_BLANK_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          e;
  logic          mode;
  logic [SW-1:0] s;
  logic          hold;
  logic [N-1:0]  y;
  logic [SW-1:0] idx;
  logic          wrap;

  typedef struct packed {
    logic [N-1:0]  y;
    logic [SW-1:0] idx;
    logic          wrap;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  int   errors = 0;
  int   checks = 0;

  logic [SW-1:0] m_idx;
  int            m_cnt;
  int            m_since;

  demux_scan #(
    .N(N), .SW(SW), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .E(e), .MODE(mode),
    .S(s), .HOLD(hold), .Y(y), .IDX(idx), .WRAP(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic m_reset();
    m_idx   = '0;
    m_cnt   = 0;
    m_since = BLANK;
    q.delete();
  endtask

  // Model: m_since counts edges since the last channel change.
  task automatic model_push();
    logic [SW-1:0] ni;
    int            nc;
    logic          nw;
    exp_t          x;
    nw = 1'b0;
    if (!mode) begin
      ni = s;
      nc = 0;
    end else if (hold) begin
      ni = m_idx;
      nc = m_cnt;
    end else if (m_cnt == DIV - 1) begin
      ni = m_idx + 4'd1;
      nc = 0;
      nw = (m_idx == 4'd15);
    end else begin
      ni = m_idx;
      nc = m_cnt + 1;
    end
    if (BLK_EN && ni != m_idx) m_since = 0;
    else if (m_since < BLANK) m_since++;
    x.y = '0;
    if (m_since >= BLANK) x.y[ni] = e;
    x.idx  = ni;
    x.wrap = nw;
    m_idx  = ni;
    m_cnt  = nc;
    q.push_back(x);
  endtask

  task automatic step();
    model_push();
    @(posedge clk);
    #1;
    ex = q.pop_front();
  endtask

  task automatic align_scan();
    mode = 1'b0;
    s    = '0;
    hold = 1'b0;
    repeat (3) step();
    mode = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e     = 1'b1;
    mode  = 1'b1;
    s     = '0;
    hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (y !== '0) begin
      errors++;
      $display("FAIL rst_y: got %h want 0000", y);
    end
    checks++;
    if (idx !== '0) begin
      errors++;
      $display("FAIL rst_idx: got %0d want 0", idx);
    end
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_wrap: got %b want 0", wrap);
    end
    rst_n = 1'b1;
    m_reset();
    step();
    checks++;
    if (y !== 16'h0001 || idx !== 4'd0) begin
      errors++;
      $display("FAIL rst_release: y=%h idx=%0d want 0001/0", y, idx);
    end
  endtask

  task automatic test_manual();
    mode = 1'b0;
    hold = 1'b0;
    e    = 1'b1;
    s    = 4'd5;
    step();
    checks++;
    if (idx !== 4'd5 || ex.y !== y || wrap !== 1'b0) begin
      errors++;
      $display("FAIL man_s5: idx=%0d y=%h want 5/%h", idx, y, ex.y);
    end
    repeat (2) step();
    checks++;
    if (y !== 16'h0020) begin
      errors++;
      $display("FAIL man_y5: got %h want 0020", y);
    end
    e = 1'b0;
    step();
    checks++;
    if (y !== 16'h0000) begin
      errors++;
      $display("FAIL man_e0: got %h want 0000", y);
    end
    e = 1'b1;
    s = 4'd9;
    for (int k = 1; k <= 3; k++) begin
      logic [N-1:0] want;
      step();
      want = (BLK_EN && k < 3) ? 16'h0000 : 16'h0200;
      checks++;
      if (y !== want || idx !== 4'd9) begin
        errors++;
        $display("FAIL man_s9 k=%0d: y=%h idx=%0d want %h/9",
                 k, y, idx, want);
      end
    end
    s = 4'd15;
    step();
    s = 4'd0;
    step();
    checks++;
    if (wrap !== 1'b0 || idx !== 4'd0) begin
      errors++;
      $display("FAIL man_load0: wrap=%b idx=%0d want 0/0", wrap, idx);
    end
    for (int k = 0; k < 32; k++) begin
      if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
      e    = 1'($urandom);
      hold = 1'($urandom);
      step();
      checks++;
      if (y !== ex.y || idx !== ex.idx || wrap !== ex.wrap) begin
        errors++;
        $display("FAIL man_rand k=%0d: y=%h/%h idx=%0d/%0d wrap=%b/%b",
                 k, y, ex.y, idx, ex.idx, wrap, ex.wrap);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_scan();
    int wraps;
    int first_w;
    int last_w;
    align_scan();
    e       = 1'b1;
    wraps   = 0;
    first_w = -1;
    last_w  = -1;
    for (int t = 1; t <= 130; t++) begin
      step();
      checks++;
      if (y !== ex.y || idx !== ex.idx || wrap !== ex.wrap) begin
        errors++;
        $display("FAIL scan_model t=%0d: y=%h/%h idx=%0d/%0d wrap=%b/%b",
                 t, y, ex.y, idx, ex.idx, wrap, ex.wrap);
      end
      checks++;
      if (idx !== 4'((t / DIV) % N)) begin
        errors++;
        $display("FAIL scan_idx t=%0d: got %0d want %0d",
                 t, idx, (t / DIV) % N);
      end
      if (wrap === 1'b1) begin
        wraps++;
        if (first_w < 0) first_w = t;
        else last_w = t;
        checks++;
        if (idx !== 4'd0) begin
          errors++;
          $display("FAIL wrap_idx t=%0d: got %0d want 0", t, idx);
        end
      end
    end
    checks++;
    if (wraps !== 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 2", wraps);
    end
    checks++;
    if (last_w - first_w !== N * DIV) begin
      errors++;
      $display("FAIL wrap_period: got %0d want %0d",
               last_w - first_w, N * DIV);
    end
  endtask

  task automatic test_hold();
    align_scan();
    e = 1'b1;
    repeat (13) step();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (idx !== 4'd3 || y !== 16'h0008 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold k=%0d: idx=%0d y=%h want 3/0008", k, idx, y);
      end
    end
    hold = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      logic [SW-1:0] want;
      step();
      want = (k < 3) ? 4'd3 : 4'd4;
      checks++;
      if (idx !== want || y !== ex.y) begin
        errors++;
        $display("FAIL hold_rel k=%0d: idx=%0d y=%h want %0d/%h",
                 k, idx, y, want, ex.y);
      end
    end
  endtask

  task automatic test_mode_switch();
    align_scan();
    e = 1'b1;
    repeat (30) step();
    checks++;
    if (idx !== 4'd7) begin
      errors++;
      $display("FAIL ms_pre: idx=%0d want 7", idx);
    end
    mode = 1'b0;
    s    = 4'd2;
    step();
    checks++;
    if (idx !== 4'd2 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL ms_manual: idx=%0d wrap=%b want 2/0", idx, wrap);
    end
    mode = 1'b1;
    s    = 4'd9;
    for (int k = 1; k <= 4; k++) begin
      logic [SW-1:0] want;
      step();
      want = (k < 4) ? 4'd2 : 4'd3;
      checks++;
      if (idx !== want || wrap !== 1'b0 || y !== ex.y) begin
        errors++;
        $display("FAIL ms_scan k=%0d: idx=%0d wrap=%b y=%h want %0d/0/%h",
                 k, idx, wrap, y, want, ex.y);
      end
    end
  endtask

  task automatic test_reset_mid_blank();
    mode = 1'b0;
    hold = 1'b0;
    e    = 1'b1;
    s    = 4'd3;
    repeat (3) step();
    s = 4'd12;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (y !== '0 || idx !== '0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: y=%h idx=%0d wrap=%b want 0/0/0",
               y, idx, wrap);
    end
    @(posedge clk);
    #1;
    mode = 1'b1;
    s    = 4'd0;
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (y !== 16'h0001 || idx !== 4'd0 || y !== ex.y) begin
      errors++;
      $display("FAIL post_rst: y=%h idx=%0d want 0001/0", y, idx);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_mode_switch();
    test_reset_mid_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_scan.md
# demux_scan

Registered, parametrised 1:N demultiplexer with an optional auto-scan sequencer. It is the clocked successor to the combinational 1:16 demux. It routes enable input E to one of N one-hot outputs, selected either directly by S (manual mode) or by an internal dwell counter that steps through every channel (scan mode, e.g. display-digit or LED-column multiplexing). It sits between the control datapath and the output drivers, and all outputs are glitch-free registers.

## Interface
- N, 16, channel count; power of two, 2..64
- SW, 4, select width; must equal log2(N)
- DIV, 1000, dwell cycles per channel in scan mode; ≥2
- BLANK, 2, blanking cycles after each channel change; 1..DIV-1; used only with DEMUX_SCAN_BLANK_EN
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous reset, active low
- E  in  1  data/enable routed to the selected channel
- MODE  in  1  0 = manual select from S, 1 = auto-scan
- S  in  SW  manual channel select
- HOLD  in  1  scan mode: freeze dwell counter and IDX
- Y  out  N  one-hot (or all-zero) registered outputs
- IDX  out  SW  currently selected channel
- WRAP  out  1  one-cycle pulse when scan wraps from N-1 to 0

## Operation
- Reset (RST_N low, asynchronous): Y=0, IDX=0, WRAP=0, dwell counter=0, FSM=RUN.
- Output rule: every cycle, Y[IDX_next] <= E and all other bits <= 0. Y is never multi-hot.
- Manual mode (MODE=0): IDX <= S every cycle. The dwell counter is held at 0. HOLD is ignored. WRAP=0.
- Scan mode (MODE=1): the dwell counter counts 0..DIV-1.
  - At DIV-1 with HOLD=0: IDX <= (IDX+1) mod N and the counter returns to 0.
  - HOLD=1: counter and IDX are frozen. Y keeps tracking E.
- WRAP=1 for exactly the one cycle in which IDX becomes 0 from N-1 in scan mode. A manual load to 0 never raises WRAP.
- Mode change 0->1: scanning starts from the current IDX with the counter cleared, giving a full DIV dwell on that channel.
- Mode change 1->0: IDX <= S on the same edge and the counter is cleared.
- Index arithmetic is SW bits wide and wraps naturally. No out-of-range index exists.
- FSM has two states:
  - RUN: Y follows E on IDX.
  - BLNK: Y forced to 0.
  - RUN->BLNK on any cycle where IDX changes value, and only when blanking is compiled in.
  - BLNK->RUN after BLANK cycles.
  - An IDX change while in BLNK restarts the blank count.
  - Reloading the same S value is not a change.
- In scan mode, blanking cycles count toward DIV. Channel period stays exactly DIV cycles.

## Timing
- E or S to Y: 1 clock (registered), when no blanking applies.
- Scan: IDX changes exactly every DIV cycles with HOLD=0. Full frame is N*DIV cycles and WRAP period is N*DIV.
- With blanking: after an IDX change, Y=0 for BLANK cycles, then Y[IDX]=E from cycle BLANK+1.
- Reset mid-dwell or mid-blank clears everything immediately. The first post-reset edge in scan mode begins a fresh dwell on channel 0.
- HOLD asserted in the cycle the counter is at DIV-1 suppresses that step. The step occurs on the first cycle after HOLD deasserts.

## Configuration
- DEMUX_SCAN_BLANK_EN defined: the BLNK state and blank counter exist, and channel changes are blanked for BLANK cycles as described above.
- DEMUX_SCAN_BLANK_EN undefined: there is no BLNK state. Y switches directly from the old channel to the new one in a single edge, and BLANK is ignored.

## Test plan
- Reset: hold RST_N=0 with E=1, MODE=1 -> Y=0, IDX=0, WRAP=0. Release RST_N -> Y=0x0001 one edge later.
- Manual: MODE=0, E=1, S=5 -> Y=0x0020 and IDX=5 after 1 clock. S=5, E=0 -> Y=0x0000. With blanking enabled (BLANK=2), S 5->9 -> Y=0 for 2 cycles, then 0x0200.
- Scan: N=16, DIV=4, E=1, blanking disabled -> IDX steps 0,1,…,15,0 every 4 cycles. WRAP is high for exactly 1 cycle every 64 cycles, coincident with IDX=0.
- HOLD: HOLD=1 for 10 cycles while IDX=3 -> IDX stays 3 and Y=0x0008. After release, IDX=4 appears after the remaining dwell.
- Mode switch: scanning at IDX=7, set MODE=0 with S=2 -> IDX=2 next edge and WRAP stays 0. Return to MODE=1 -> a 4-cycle dwell on channel 2 before IDX=3.
- Async reset mid-blank: drop RST_N during a BLNK cycle between clock edges -> Y=0 and IDX=0 immediately. No residual blank occurs after release.
